// File: rtl/arch_defs_pkg.sv
// Shared architecture constants and types for the CPU/ROM boundary.
package arch_defs_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int ROM_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } rom_owner_e;

endpackage

// File: rtl/rom_arb_starve_counter.sv
// Saturating count of consecutive cycles fetch was refused; at_limit once LIMIT is reached.
module rom_arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int              CW  = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0]   LIM = LIMIT[CW-1:0];

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/rom_access_arbiter.sv
// Arbitrates fetch/data onto a 1-cycle-latency ROM: grant and address same cycle, data one cycle later.
// Optional grant/starvation statistics outputs when ROM_ARB_STATS_EN is defined.
module rom_access_arbiter
  import arch_defs_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int ROM_ADDR_WIDTH = arch_defs_pkg::ROM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_req,
  input  logic [ROM_ADDR_WIDTH-1:0] fetch_addr,
  input  logic                      fetch_flush,
  output logic                      fetch_gnt,
  output logic                      fetch_rvalid,
  output logic [DATA_WIDTH-1:0]     fetch_rdata,
  input  logic                      data_req,
  input  logic [ROM_ADDR_WIDTH-1:0] data_addr,
  output logic                      data_gnt,
  output logic                      data_rvalid,
  output logic [DATA_WIDTH-1:0]     data_rdata,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [15:0]               fetch_grant_count,
  output logic [15:0]               data_grant_count,
  output logic [15:0]               starve_events
`endif
);

  logic                      at_limit;
  logic                      starve_win;
  logic                      fetch_wait;
  logic [ROM_ADDR_WIDTH-1:0] addr_q;
  rom_owner_e                owner_q;
  rom_owner_e                owner_d;
  logic                      kill_q;

  rom_arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (fetch_wait),
    .clr      (!fetch_wait),
    .at_limit (at_limit)
  );

  assign fetch_wait = fetch_req && !fetch_gnt;

  always_comb begin
    starve_win = (STARVE_LIMIT != 0) && at_limit && fetch_req;
    data_gnt   = 1'b0;
    fetch_gnt  = 1'b0;
    if (!reset) begin
      data_gnt  = data_req && !starve_win;
      fetch_gnt = fetch_req && !data_gnt;
    end

    // Idle cycles replay the last address so the ROM input never toggles.
    rom_addr = addr_q;
    owner_d  = OWNER_NONE;
    if (fetch_gnt) begin
      rom_addr = fetch_addr;
      owner_d  = OWNER_FETCH;
    end else if (data_gnt) begin
      rom_addr = data_addr;
      owner_d  = OWNER_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      owner_q <= OWNER_NONE;
      kill_q  <= 1'b0;
    end else begin
      addr_q  <= rom_addr;
      owner_q <= owner_d;
      kill_q  <= fetch_gnt && fetch_flush;
    end
  end

  // A fetch is dropped if flushed at grant time (kill_q) or while its data returns.
  assign fetch_rvalid = !reset && (owner_q == OWNER_FETCH) && !kill_q && !fetch_flush;
  assign data_rvalid  = !reset && (owner_q == OWNER_DATA);
  assign fetch_rdata  = fetch_rvalid ? rom_data : '0;
  assign data_rdata   = data_rvalid  ? rom_data : '0;

`ifdef ROM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_grant_count <= '0;
      data_grant_count  <= '0;
      starve_events     <= '0;
    end else begin
      if (fetch_gnt) fetch_grant_count <= fetch_grant_count + 16'd1;
      if (data_gnt)  data_grant_count  <= data_grant_count + 16'd1;
      if (fetch_gnt && data_req) starve_events <= starve_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Randomized and directed bench for rom_access_arbiter against a transaction-level model.
module tb_rom_access_arbiter;
  import arch_defs_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_flush, data_req;
  logic [11:0] fetch_addr, data_addr, rom_addr;
  logic        fetch_gnt, fetch_rvalid, data_gnt, data_rvalid;
  logic [7:0]  fetch_rdata, data_rdata;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  mem [0:4095];
`ifdef ROM_ARB_STATS_EN
  logic [15:0] fetch_grant_count, data_grant_count, starve_events;
`endif

  rom_access_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_flush  (fetch_flush),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_gnt     (data_gnt),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data)
`ifdef ROM_ARB_STATS_EN
    ,
    .fetch_grant_count (fetch_grant_count),
    .data_grant_count  (data_grant_count),
    .starve_events     (starve_events)
`endif
  );

  always #5 clk = ~clk;

  // ROM: registered read, one cycle latency
  always @(posedge clk) rom_data <= mem[rom_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: waiting-cycle count for fetch and the single pending response.
  int          wait_cnt  = 0;
  int          p_owner   = 0;   // 0 none, 1 fetch, 2 data
  logic [11:0] p_addr    = '0;
  bit          p_kill    = 0;
  logic [11:0] last_addr = '0;
`ifdef ROM_ARB_STATS_EN
  int m_fc = 0, m_dc = 0, m_se = 0;
`endif

  always @(negedge clk) begin : model
    bit          starve, eg_d, eg_f, ef_v, ed_v;
    logic [11:0] ea;
    logic [7:0]  pd;
    if (reset) begin
      check("m_rst_fgnt", 32'(fetch_gnt), 0);
      check("m_rst_dgnt", 32'(data_gnt), 0);
      check("m_rst_frv",  32'(fetch_rvalid), 0);
      check("m_rst_drv",  32'(data_rvalid), 0);
      wait_cnt = 0; p_owner = 0; p_kill = 0; last_addr = '0;
`ifdef ROM_ARB_STATS_EN
      m_fc = 0; m_dc = 0; m_se = 0;
`endif
    end else begin
      starve = (LIMIT != 0) && (wait_cnt >= LIMIT) && fetch_req;
      eg_d   = data_req && !starve;
      eg_f   = fetch_req && !eg_d;
      ea     = eg_f ? fetch_addr : (eg_d ? data_addr : last_addr);
      ef_v   = (p_owner == 1) && !p_kill && !fetch_flush;
      ed_v   = (p_owner == 2);
      pd     = mem[p_addr];
      check("m_fgnt",    32'(fetch_gnt), 32'(eg_f));
      check("m_dgnt",    32'(data_gnt), 32'(eg_d));
      check("m_romaddr", 32'(rom_addr), 32'(ea));
      check("m_frv",     32'(fetch_rvalid), 32'(ef_v));
      check("m_drv",     32'(data_rvalid), 32'(ed_v));
      check("m_frd",     32'(fetch_rdata), ef_v ? 32'(pd) : 0);
      check("m_drd",     32'(data_rdata), ed_v ? 32'(pd) : 0);
`ifdef ROM_ARB_STATS_EN
      check("m_fcnt", 32'(fetch_grant_count), 32'(m_fc));
      check("m_dcnt", 32'(data_grant_count), 32'(m_dc));
      check("m_scnt", 32'(starve_events), 32'(m_se));
      if (eg_f) m_fc = (m_fc + 1) & 16'hFFFF;
      if (eg_d) m_dc = (m_dc + 1) & 16'hFFFF;
      if (eg_f && data_req) m_se = (m_se + 1) & 16'hFFFF;
`endif
      if (fetch_req && !eg_f) wait_cnt = (wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT;
      else wait_cnt = 0;
      p_owner   = eg_f ? 1 : (eg_d ? 2 : 0);
      p_addr    = ea;
      p_kill    = eg_f && fetch_flush;
      last_addr = ea;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req = 0; data_req = 0; fetch_flush = 0;
  endtask

  initial begin
    logic [7:0] pv [3];
    bit f_took, d_took;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[12'h010] = 8'hA5;
    mem[12'h020] = 8'h77;
    mem[12'h100] = 8'h3C; mem[12'h101] = 8'hC3; mem[12'h102] = 8'h5A;
    mem[12'h300] = 8'h9E;
    pv[0] = 8'h3C; pv[1] = 8'hC3; pv[2] = 8'h5A;

    // Reset with both requesting: no grants
    reset = 1; fetch_req = 1; data_req = 1; fetch_flush = 0;
    fetch_addr = 12'h555; data_addr = 12'h666;
    repeat (2) @(negedge clk);
    check("rst_fgnt", 32'(fetch_gnt), 0);
    check("rst_dgnt", 32'(data_gnt), 0);
    step(); reset = 0; idle();
    @(negedge clk);
    check("rst_romaddr", 32'(rom_addr), 0);
    check("rst_drv", 32'(data_rvalid), 0);

    // Fetch only
    step(); fetch_req = 1; fetch_addr = 12'h010;
    @(negedge clk);
    check("fo_gnt", 32'(fetch_gnt), 1);
    check("fo_addr", 32'(rom_addr), 32'h010);
    step(); idle();
    @(negedge clk);
    check("fo_rvalid", 32'(fetch_rvalid), 1);
    check("fo_rdata", 32'(fetch_rdata), 32'hA5);
    check("fo_drv", 32'(data_rvalid), 0);
    check("fo_hold", 32'(rom_addr), 32'h010);

    // Contention: data 4 cycles, then fetch
    step(); fetch_req = 1; data_req = 1; fetch_addr = 12'h000; data_addr = 12'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ct_dgnt", 32'(data_gnt), (i % 5 != 4) ? 1 : 0);
      check("ct_fgnt", 32'(fetch_gnt), (i % 5 == 4) ? 1 : 0);
      if (i > 0) check("ct_drv", 32'(data_rvalid), ((i - 1) % 5 != 4) ? 1 : 0);
    end
    step(); idle();

    // Pipelined data reads
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 3) begin data_req = 1; data_addr = 12'h100 + 12'(k); end
      else data_req = 0;
      @(negedge clk);
      if (k < 3) check("pl_gnt", 32'(data_gnt), 1);
      if (k >= 1 && k <= 3) begin
        check("pl_rvalid", 32'(data_rvalid), 1);
        check("pl_rdata", 32'(data_rdata), 32'(pv[k-1]));
      end
      if (k == 4) check("pl_end", 32'(data_rvalid), 0);
    end

    // Flush while response returns; data alongside is unaffected
    step(); fetch_req = 1; fetch_addr = 12'h020;
    @(negedge clk);
    check("fl_gnt", 32'(fetch_gnt), 1);
    step(); fetch_req = 0; fetch_flush = 1; data_req = 1; data_addr = 12'h300;
    @(negedge clk);
    check("fl_frv", 32'(fetch_rvalid), 0);
    check("fl_dgnt", 32'(data_gnt), 1);
    step(); idle();
    @(negedge clk);
    check("fl_drv", 32'(data_rvalid), 1);
    check("fl_drd", 32'(data_rdata), 32'h9E);

    // Flush coincident with grant kills the response
    step(); fetch_req = 1; fetch_flush = 1; fetch_addr = 12'h020;
    @(negedge clk);
    check("fk_gnt", 32'(fetch_gnt), 1);
    step(); idle();
    @(negedge clk);
    check("fk_frv", 32'(fetch_rvalid), 0);

    // Reset drops an in-flight data response
    step(); data_req = 1; data_addr = 12'h300;
    @(negedge clk);
    check("rm_gnt", 32'(data_gnt), 1);
    step(); data_req = 0; reset = 1;
    @(negedge clk);
    check("rm_drv0", 32'(data_rvalid), 0);
    step(); reset = 0;
    @(negedge clk);
    check("rm_drv1", 32'(data_rvalid), 0);
    check("rm_addr", 32'(rom_addr), 0);

    // Reset clears a partially-built starve count
    step(); fetch_req = 1; data_req = 1; fetch_addr = 12'h040; data_addr = 12'h300;
    step(); step(); step(); reset = 1;
    step(); reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rc_dgnt", 32'(data_gnt), (i != 4) ? 1 : 0);
    end
    step(); idle();

    // Randomized traffic honouring the hold-until-granted contract
    f_took = 0; d_took = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (!fetch_req || f_took || reset) begin
        fetch_req = ($urandom_range(0, 99) < 60); fetch_addr = 12'($urandom);
      end else if ($urandom_range(0, 99) < 3) fetch_req = 0;
      if (!data_req || d_took || reset) begin
        data_req = ($urandom_range(0, 99) < 55); data_addr = 12'($urandom);
      end else if ($urandom_range(0, 99) < 3) data_req = 0;
      fetch_flush = ($urandom_range(0, 99) < 10);
      reset = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      f_took = fetch_gnt; d_took = data_gnt;
    end
    step(); idle(); reset = 0;

`ifdef ROM_ARB_STATS_EN
    step(); reset = 1;
    step(); reset = 0;
    for (int i = 0; i < 8; i++) begin
      step(); idle();
      if (i < 3) begin fetch_req = 1; fetch_addr = 12'(i); end
      else begin data_req = 1; data_addr = 12'(i); end
    end
    step(); idle();
    @(negedge clk);
    check("st_fcnt", 32'(fetch_grant_count), 3);
    check("st_dcnt", 32'(data_grant_count), 5);
    step(); fetch_req = 1;
    repeat (65533) step();
    idle();
    @(negedge clk);
    check("st_wrap", 32'(fetch_grant_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
